uart_rx_fsm: RTL and testbench

// UART receive stage. Consumes the serial line driven by the UART transmit FSM/shift path.

---
 rtl/uart_rx_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// UART receive stage. Recovers frames of 1 start bit, 8 data bits (LSB first),
// an optional parity bit and 1 stop bit from an oversampled serial line.
// Each received byte is delivered with a one-cycle valid strobe and error flags.
//
// Parameters
//   OVERSAMPLE  clk cycles per serial bit (even, >= 4)
//   PARITY_EN   1: a parity bit follows the data, 0: stop bit follows bit 7
//   PARITY_ODD  0: even parity, 1: odd parity
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   rx_in       in   serial line, idles high, asynchronous to clk
//   rx_data     out  received byte, held until the next rx_valid
//   rx_valid    out  one-cycle strobe qualifying rx_data and the error flags
//   parity_err  out  parity mismatch on the strobed frame (0 when PARITY_EN=0)
//   frame_err   out  stop bit sampled low on the strobed frame
//   busy        out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW          = $clog2(OVERSAMPLE);
    localparam int SYNC_STAGES = 2;

    // Start bit is checked at its midpoint; every later bit is sampled one
    // full bit period after the previous sample, i.e. also at its midpoint.
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    localparam logic PAR_EN_BIT  = (PARITY_EN != 0);
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA_BIT,
        S_PARITY_BIT,
        S_STOP_BIT,
        S_BREAK_WAIT
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. Flops reset to 1 so a reset never looks like a
    // start edge.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= rx_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t          state_reg,      state_next;
    logic [CW-1:0]   cnt_reg,        cnt_next;
    logic [2:0]      bit_idx_reg,    bit_idx_next;
    logic [7:0]      shift_reg,      shift_next;
    logic            parity_ok_reg,  parity_ok_next;
    logic [7:0]      rx_data_reg,    rx_data_next;
    logic            rx_valid_reg,   rx_valid_next;
    logic            parity_err_reg, parity_err_next;
    logic            frame_err_reg,  frame_err_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= CNT_ZERO;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_ok_reg  <= 1'b1;
            rx_data_reg    <= 8'h00;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            parity_ok_reg  <= parity_ok_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + CNT_ONE;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        parity_ok_next  = parity_ok_reg;
        rx_data_next    = rx_data_reg;
        // Strobe and flags default low so they last exactly one cycle and
        // read 0 whenever no frame is being delivered.
        rx_valid_next   = 1'b0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                cnt_next = CNT_ZERO;
                if (!rx_s) begin
                    state_next     = S_START_BIT;
                    parity_ok_next = 1'b1;
                end
            end

            S_START_BIT: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = CNT_ZERO;
                    if (rx_s) begin
                        // Line went back high before mid-bit: a glitch.
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_DATA_BIT;
                        bit_idx_next = 3'd0;
                    end
                end
            end

            S_DATA_BIT: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next                = CNT_ZERO;
                    shift_next[bit_idx_reg] = rx_s;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = PAR_EN_BIT ? S_PARITY_BIT : S_STOP_BIT;
                    end
                end
            end

            S_PARITY_BIT: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next       = CNT_ZERO;
                    parity_ok_next = ((^shift_reg) ^ rx_s ^ PAR_ODD_BIT) == 1'b0;
                    state_next     = S_STOP_BIT;
                end
            end

            S_STOP_BIT: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next        = CNT_ZERO;
                    rx_valid_next   = 1'b1;
                    rx_data_next    = shift_reg;
                    parity_err_next = PAR_EN_BIT & ~parity_ok_reg;
                    frame_err_next  = ~rx_s;
                    // Returning to IDLE at the stop midpoint leaves half a bit
                    // to catch a back-to-back start edge. A low stop bit means
                    // the line may be held in break; wait for it to rise.
                    state_next      = rx_s ? S_IDLE : S_BREAK_WAIT;
                end
            end

            S_BREAK_WAIT: begin
                cnt_next = CNT_ZERO;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed bench for uart_rx_fsm (OVERSAMPLE=16, PARITY_EN=1, PARITY_ODD=0).
// Inputs are driven on the falling clock edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

    localparam int BIT_T = 16;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // strobe log
    int         strobe_cnt = 0;
    logic [7:0] st_data [0:31];
    logic       st_pe   [0:31];
    logic       st_fe   [0:31];
    int         st_cyc  [0:31];
    int         flag_viol  = 0;
    int         dbl_pulse  = 0;
    logic       prev_valid = 1'b0;

    int start_cyc = 0;
    int busy_low  = 0;

    uart_rx_fsm #(
        .OVERSAMPLE(16),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (strobe_cnt < 32) begin
                st_data[strobe_cnt] = rx_data;
                st_pe[strobe_cnt]   = parity_err;
                st_fe[strobe_cnt]   = frame_err;
                st_cyc[strobe_cnt]  = cyc;
            end
            strobe_cnt = strobe_cnt + 1;
            if (prev_valid) dbl_pulse = dbl_pulse + 1;
        end else if (parity_err || frame_err) begin
            flag_viol = flag_viol + 1;
        end
        prev_valid = rx_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one 11-bit frame starting at the current falling edge.
    // Counts busy-low cycles from 3 to 170 falling edges after the start,
    // the window in which the receiver must be mid-frame.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        int          k;
        bits      = {s, p, d, 1'b0};
        start_cyc = cyc;
        k         = 0;
        for (int b = 0; b < 11; b++) begin
            rx_in = bits[b];
            for (int t = 0; t < BIT_T; t++) begin
                @(negedge clk);
                k = k + 1;
                if (k >= 3 && k <= 170 && !busy) busy_low = busy_low + 1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int idx;
        logic [10:0] bits;

        reset = 1'b0;
        rx_in = 1'b1;
        repeat (4) @(negedge clk);

        // reset state
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_flags", {parity_err, frame_err}, 0);

        reset = 1'b1;
        idle_cycles(10);
        check_eq("idle_busy", busy, 0);

        // 1: 0xA5 (4 ones -> parity 0), clean frame
        idx      = strobe_cnt;
        busy_low = 0;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_cycles(8);
        check_eq("t1_strobes", strobe_cnt - idx, 1);
        check_eq("t1_data", st_data[idx], 8'hA5);
        check_eq("t1_pe", st_pe[idx], 0);
        check_eq("t1_fe", st_fe[idx], 0);
        // 169 cycles after rx_s falls, plus 2 synchronizer cycles from rx_in
        check_eq("t1_latency", st_cyc[idx] - start_cyc, 171);
        check_eq("t1_busy_hold", busy_low, 0);

        // 2: 4-cycle glitch on the line
        idx   = strobe_cnt;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t2_busy_during", busy, 1);
        @(negedge clk);
        rx_in = 1'b1;
        repeat (11) @(negedge clk);
        check_eq("t2_busy_after", busy, 0);
        idle_cycles(200);
        check_eq("t2_no_strobe", strobe_cnt - idx, 0);

        // 3: 0x3C (4 ones) sent with parity 1 -> parity error
        idx = strobe_cnt;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_cycles(8);
        check_eq("t3_strobes", strobe_cnt - idx, 1);
        check_eq("t3_data", st_data[idx], 8'h3C);
        check_eq("t3_pe", st_pe[idx], 1);
        check_eq("t3_fe", st_fe[idx], 0);

        // 4: 0x81 with low stop bit, then line held low for 40 bit times
        idx = strobe_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        repeat (40 * BIT_T) @(negedge clk);
        check_eq("t4_strobes", strobe_cnt - idx, 1);
        check_eq("t4_data", st_data[idx], 8'h81);
        check_eq("t4_fe", st_fe[idx], 1);
        check_eq("t4_pe", st_pe[idx], 0);
        check_eq("t4_busy_break", busy, 1);
        idle_cycles(40);
        check_eq("t4_busy_released", busy, 0);
        idx = strobe_cnt;
        send_frame(8'h12, 1'b0, 1'b1);
        idle_cycles(8);
        check_eq("t4_next_strobes", strobe_cnt - idx, 1);
        check_eq("t4_next_data", st_data[idx], 8'h12);
        check_eq("t4_next_flags", {st_pe[idx], st_fe[idx]}, 0);

        // 5: 0x00 then 0xFF (8 ones -> parity 0) back-to-back
        idx = strobe_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_cycles(8);
        check_eq("t5_strobes", strobe_cnt - idx, 2);
        check_eq("t5_data0", st_data[idx], 8'h00);
        check_eq("t5_data1", st_data[idx+1], 8'hFF);
        check_eq("t5_flags", {st_pe[idx], st_fe[idx], st_pe[idx+1], st_fe[idx+1]}, 0);
        check_eq("t5_spacing", st_cyc[idx+1] - st_cyc[idx], 176);

        // 6: reset in the middle of the data bits of 0x5A
        idx  = strobe_cnt;
        bits = {1'b1, 1'b0, 8'h5A, 1'b0};
        for (int b = 0; b < 4; b++) begin
            rx_in = bits[b];
            repeat (BIT_T) @(negedge clk);
        end
        check_eq("t6_busy_pre", busy, 1);
        reset = 1'b0;
        rx_in = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_data", rx_data, 8'h00);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_valid_flags", {rx_valid, parity_err, frame_err}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_cycles(200);
        check_eq("t6_no_strobe", strobe_cnt - idx, 0);
        send_frame(8'h33, 1'b0, 1'b1);
        idle_cycles(8);
        check_eq("t6_strobes", strobe_cnt - idx, 1);
        check_eq("t6_data", st_data[idx], 8'h33);
        check_eq("t6_flags", {st_pe[idx], st_fe[idx]}, 0);

        // strobe-shape properties across the whole run
        check_eq("flags_outside_strobe", flag_viol, 0);
        check_eq("strobe_width", dbl_pulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
